// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// optional 2-entry skid buffer and saturating stall/bubble counters.
// Control bits and payload read as zero whenever the stage holds no entry,
// so downstream write enables can never fire on a bubble.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic w_in_xfer;
   logic w_out_xfer;

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_FULL  = 2'd2
         } state_t;

         state_t            r_state;
         logic              r_out_valid;
         logic              r_in_ready;
         logic [DATA_W-1:0] r_main_data;
         logic [CTRL_W-1:0] r_main_ctrl;
         logic [DATA_W-1:0] r_skid_data;
         logic [CTRL_W-1:0] r_skid_ctrl;

         // Main/skid occupancy FSM; in_ready is registered so out_ready never
         // reaches the upstream stage combinationally.
         always_ff @(posedge clk) begin
            // NOTE: payload registers are reset along with the valid bits,
            // because an empty stage must present all-zero data and control.
            if (rst || flush) begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_main_data <= '0;
               r_main_ctrl <= '0;
               r_skid_data <= '0;
               r_skid_ctrl <= '0;
            end else begin
               // NOTE: non-blocking assignments only, so every register
               // below sees the pre-edge value of every other register.
               case (r_state)
                  ST_EMPTY: begin
                     if (w_in_xfer) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                     end
                  end
                  ST_ONE: begin
                     if (w_in_xfer && w_out_xfer) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                     end else if (w_in_xfer) begin
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_FULL;
                     end else if (w_out_xfer) begin
                        r_main_data <= '0;
                        r_main_ctrl <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                     end
                  end
                  ST_FULL: begin
                     if (w_out_xfer) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_skid_data <= '0;
                        r_skid_ctrl <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ONE;
                     end
                  end
                  default: begin
                     r_state     <= ST_EMPTY;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_main_data <= '0;
                     r_main_ctrl <= '0;
                     r_skid_data <= '0;
                     r_skid_ctrl <= '0;
                  end
               endcase
            end
         end

         assign in_ready  = r_in_ready;
         assign out_valid = r_out_valid;
         assign out_data  = r_main_data;
         assign out_ctrl  = r_main_ctrl;
      end else begin : g_single
         logic              r_out_valid;
         logic [DATA_W-1:0] r_main_data;
         logic [CTRL_W-1:0] r_main_ctrl;

         // Single register: load on accept, clear when drained without refill.
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               r_out_valid <= 1'b0;
               r_main_data <= '0;
               r_main_ctrl <= '0;
            end else if (w_in_xfer) begin
               r_out_valid <= 1'b1;
               r_main_data <= in_data;
               r_main_ctrl <= in_ctrl;
            end else if (w_out_xfer) begin
               r_out_valid <= 1'b0;
               r_main_data <= '0;
               r_main_ctrl <= '0;
            end
         end

         assign in_ready  = out_ready | ~r_out_valid;
         assign out_valid = r_out_valid;
         assign out_data  = r_main_data;
         assign out_ctrl  = r_main_ctrl;
      end
   endgenerate

   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   // Saturating performance counters; they keep counting through flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         if (!out_valid && out_ready && (r_bubble_cnt != CNT_MAX))
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid-buffered instance (16-bit counters) and
// one single-register instance (4-bit counters), each shadowed by a bounded
// FIFO reference model.
module tb_pipe_stage_reg;

   localparam int DW      = 32;
   localparam int CW      = 8;
   localparam int A_CNT_W = 16;
   localparam int B_CNT_W = 4;
   localparam int A_MAX   = 65535;
   localparam int B_MAX   = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic               a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [DW-1:0]      a_in_data, a_out_data;
   logic [CW-1:0]      a_in_ctrl, a_out_ctrl;
   logic [A_CNT_W-1:0] a_stall_cnt, a_bubble_cnt;

   logic               b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [DW-1:0]      b_in_data, b_out_data;
   logic [CW-1:0]      b_in_ctrl, b_out_ctrl;
   logic [B_CNT_W-1:0] b_stall_cnt, b_bubble_cnt;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(A_CNT_W)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
      .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(B_CNT_W)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
      .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
   );

   // Reference model: each stage is a FIFO of {data, ctrl} with capacity 2 (A) or 1 (B).
   logic [DW+CW-1:0] qa[$];
   logic [DW+CW-1:0] qb[$];
   int ma_stall = 0, ma_bubble = 0, mb_stall = 0, mb_bubble = 0;

   int total = 0;
   int bad   = 0;

   task automatic idle_inputs();
      a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_flush = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_flush = 1'b0; b_out_ready = 1'b0;
   endtask

   // Advance one clock and apply the handshake rules to both models.
   task automatic tick();
      logic ov, ix, ox;
      @(posedge clk);
      if (rst) begin
         qa.delete(); qb.delete();
         ma_stall = 0; ma_bubble = 0; mb_stall = 0; mb_bubble = 0;
      end else begin
         ov = (qa.size() != 0);
         if (ov && !a_out_ready && ma_stall < A_MAX) ma_stall++;
         if (!ov && a_out_ready && ma_bubble < A_MAX) ma_bubble++;
         ix = a_in_valid && (qa.size() < 2);
         ox = ov && a_out_ready;
         if (a_flush) qa.delete();
         else begin
            if (ox) void'(qa.pop_front());
            if (ix) qa.push_back({a_in_data, a_in_ctrl});
         end

         ov = (qb.size() != 0);
         if (ov && !b_out_ready && mb_stall < B_MAX) mb_stall++;
         if (!ov && b_out_ready && mb_bubble < B_MAX) mb_bubble++;
         ix = b_in_valid && ((qb.size() == 0) || b_out_ready);
         ox = ov && b_out_ready;
         if (b_flush) qb.delete();
         else begin
            if (ox) void'(qb.pop_front());
            if (ix) qb.push_back({b_in_data, b_in_ctrl});
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [CW+DW+2*A_CNT_W:0] act_a;
      logic [CW+DW+2*B_CNT_W:0] act_b;
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = $urandom; a_in_ctrl = CW'($urandom); a_out_ready = 1'b1;
         b_in_valid = 1'b1; b_in_data = $urandom; b_in_ctrl = CW'($urandom); b_out_ready = 1'b1;
         a_flush = 1'($urandom); b_flush = 1'($urandom);
         tick();
         act_a = {a_out_valid, a_out_ctrl, a_out_data, a_stall_cnt, a_bubble_cnt};
         act_b = {b_out_valid, b_out_ctrl, b_out_data, b_stall_cnt, b_bubble_cnt};
         total++;
         if (act_a !== '0) begin
            bad++;
            $display("FAIL reset_a cycle %0d: got %h, want all zero", i, act_a);
         end
         total++;
         if (act_b !== '0) begin
            bad++;
            $display("FAIL reset_b cycle %0d: got %h, want all zero", i, act_b);
         end
      end
      idle_inputs();
      rst = 1'b0;
      total++;
      if (a_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready_a: got %b, want 1", a_in_ready);
      end
      total++;
      if (b_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready_b: got %b, want 1", b_in_ready);
      end
      tick();
      total++;
      if ({a_in_ready, a_out_valid, a_stall_cnt, a_bubble_cnt} !== {2'b10, 32'd0}) begin
         bad++;
         $display("FAIL post_reset_a: in_ready=%b out_valid=%b stall=%0d bubble=%0d, want 1 0 0 0",
                  a_in_ready, a_out_valid, a_stall_cnt, a_bubble_cnt);
      end
   endtask

   task automatic test_stream();
      logic [CW-1:0] ctl[4];
      a_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ctl[i] = CW'($urandom_range(1, 255));
         a_in_valid = 1'b1; a_in_data = DW'(i + 1); a_in_ctrl = ctl[i];
         if (i > 0) a_out_ready = 1'b1;
         tick();
         total++;
         if ({a_out_valid, a_out_data, a_out_ctrl, a_in_ready} !== {1'b1, DW'(i + 1), ctl[i], 1'b1}) begin
            bad++;
            $display("FAIL stream[%0d]: valid=%b data=%h ctrl=%h in_ready=%b, want 1 %h %h 1",
                     i, a_out_valid, a_out_data, a_out_ctrl, a_in_ready, i + 1, ctl[i]);
         end
      end
      a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0;
      tick();
      a_out_ready = 1'b0;
      total++;
      if ({a_out_valid, a_out_data, a_out_ctrl} !== '0) begin
         bad++;
         $display("FAIL stream_drain: valid=%b data=%h ctrl=%h, want all zero", a_out_valid, a_out_data, a_out_ctrl);
      end
      total++;
      if (a_bubble_cnt !== 16'd0 || a_stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL stream_counters: stall=%0d bubble=%0d, want 0 0", a_stall_cnt, a_bubble_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [CW-1:0] ca, cb;
      int stall0;
      stall0 = ma_stall;
      ca = CW'($urandom); cb = CW'($urandom);
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'hA; a_in_ctrl = ca;
      tick();
      a_in_data = 32'hB; a_in_ctrl = cb;
      tick();
      for (int i = 0; i < 3; i++) begin
         a_in_data = 32'hEE; a_in_ctrl = 8'hEE;
         total++;
         if ({a_in_ready, a_out_valid, a_out_data, a_out_ctrl} !== {2'b01, 32'hA, ca}) begin
            bad++;
            $display("FAIL backpressure_hold[%0d]: in_ready=%b valid=%b data=%h ctrl=%h, want 0 1 a %h",
                     i, a_in_ready, a_out_valid, a_out_data, a_out_ctrl, ca);
         end
         tick();
      end
      a_in_valid = 1'b0;
      total++;
      if (a_stall_cnt !== A_CNT_W'(stall0 + 4)) begin
         bad++;
         $display("FAIL backpressure_stall_cnt: got %0d, want %0d", a_stall_cnt, stall0 + 4);
      end
      a_out_ready = 1'b1;
      #1;
      total++;
      if (a_out_data !== 32'hA) begin
         bad++;
         $display("FAIL backpressure_first: got %h, want a", a_out_data);
      end
      tick();
      total++;
      if ({a_out_valid, a_out_data, a_out_ctrl, a_in_ready} !== {1'b1, 32'hB, cb, 1'b1}) begin
         bad++;
         $display("FAIL backpressure_second: valid=%b data=%h ctrl=%h in_ready=%b, want 1 b %h 1",
                  a_out_valid, a_out_data, a_out_ctrl, a_in_ready, cb);
      end
      tick();
      a_out_ready = 1'b0;
      total++;
      if (a_out_valid !== 1'b0 || a_stall_cnt !== A_CNT_W'(stall0 + 4)) begin
         bad++;
         $display("FAIL backpressure_end: valid=%b stall=%0d, want 0 %0d", a_out_valid, a_stall_cnt, stall0 + 4);
      end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'h11; a_in_ctrl = 8'h5A;
      tick();
      a_in_data = 32'h22; a_in_ctrl = 8'hA5;
      tick();
      a_flush = 1'b1; a_in_data = 32'hC; a_in_ctrl = 8'hFF;
      tick();
      a_flush = 1'b0; a_in_valid = 1'b0;
      total++;
      if ({a_out_valid, a_out_data, a_out_ctrl, a_in_ready} !== {1'b0, 40'd0, 1'b1}) begin
         bad++;
         $display("FAIL flush_full: valid=%b data=%h ctrl=%h in_ready=%b, want 0 0 0 1",
                  a_out_valid, a_out_data, a_out_ctrl, a_in_ready);
      end
      total++;
      if (a_stall_cnt !== A_CNT_W'(ma_stall)) begin
         bad++;
         $display("FAIL flush_counter: stall got %0d, want %0d", a_stall_cnt, ma_stall);
      end
      // Entry accepted in the flush cycle from the ONE state must also vanish.
      a_in_valid = 1'b1; a_in_data = 32'h33; a_in_ctrl = 8'h33;
      tick();
      a_flush = 1'b1; a_in_data = 32'hC; a_in_ctrl = 8'hFF;
      tick();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({a_out_valid, a_out_data, a_out_ctrl} !== '0) begin
            bad++;
            $display("FAIL flush_discard[%0d]: valid=%b data=%h ctrl=%h, want all zero",
                     i, a_out_valid, a_out_data, a_out_ctrl);
         end
         tick();
      end
      a_out_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'h5; a_in_ctrl = 8'h05;
      tick();
      a_in_valid = 1'b0; a_flush = 1'b1; a_out_ready = 1'b1;
      #1;
      total++;
      if ({a_out_valid, a_out_data} !== {1'b1, 32'h5}) begin
         bad++;
         $display("FAIL simul_deliver: valid=%b data=%h, want 1 5", a_out_valid, a_out_data);
      end
      tick();
      a_flush = 1'b0; a_out_ready = 1'b0;
      total++;
      if ({a_out_valid, a_out_data, a_out_ctrl, a_in_ready} !== {1'b0, 40'd0, 1'b1}) begin
         bad++;
         $display("FAIL simul_empty: valid=%b data=%h ctrl=%h in_ready=%b, want 0 0 0 1",
                  a_out_valid, a_out_data, a_out_ctrl, a_in_ready);
      end
   endtask

   task automatic test_saturation();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b_in_valid = 1'b1; b_in_data = 32'h77; b_in_ctrl = 8'h77;
      tick();
      b_in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      total++;
      if ({b_out_valid, b_out_data, b_in_ready} !== {1'b1, 32'h77, 1'b0}) begin
         bad++;
         $display("FAIL sat_hold: valid=%b data=%h in_ready=%b, want 1 77 0", b_out_valid, b_out_data, b_in_ready);
      end
      total++;
      if (b_stall_cnt !== 4'd15) begin
         bad++;
         $display("FAIL sat_stall: got %0d, want 15", b_stall_cnt);
      end
      b_out_ready = 1'b1;
      #1;
      total++;
      if (b_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL comb_ready_high: got %b, want 1", b_in_ready);
      end
      b_out_ready = 1'b0;
      #1;
      total++;
      if (b_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL comb_ready_low: got %b, want 0", b_in_ready);
      end
      b_out_ready = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      total++;
      if ({b_out_valid, b_stall_cnt, b_bubble_cnt} !== {1'b0, 4'd15, 4'd15}) begin
         bad++;
         $display("FAIL sat_bubble: valid=%b stall=%0d bubble=%0d, want 0 15 15", b_out_valid, b_stall_cnt, b_bubble_cnt);
      end
      b_out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [DW+CW-1:0] fa, fb;
      logic [DW+CW+2*A_CNT_W+1:0] act_a, exp_a;
      logic [DW+CW+2*B_CNT_W+1:0] act_b, exp_b;
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 149) == 0);
         a_in_valid  = 1'($urandom); a_in_data = $urandom; a_in_ctrl = CW'($urandom);
         a_out_ready = ($urandom_range(0, 3) != 0);
         a_flush     = ($urandom_range(0, 24) == 0);
         b_in_valid  = 1'($urandom); b_in_data = $urandom; b_in_ctrl = CW'($urandom);
         b_out_ready = ($urandom_range(0, 2) != 0);
         b_flush     = ($urandom_range(0, 24) == 0);
         #1;
         fa = (qa.size() != 0) ? qa[0] : '0;
         fb = (qb.size() != 0) ? qb[0] : '0;
         exp_a = {qa.size() != 0, fa, qa.size() < 2, A_CNT_W'(ma_stall), A_CNT_W'(ma_bubble)};
         act_a = {a_out_valid, a_out_data, a_out_ctrl, a_in_ready, a_stall_cnt, a_bubble_cnt};
         exp_b = {qb.size() != 0, fb, (qb.size() == 0) || b_out_ready, B_CNT_W'(mb_stall), B_CNT_W'(mb_bubble)};
         act_b = {b_out_valid, b_out_data, b_out_ctrl, b_in_ready, b_stall_cnt, b_bubble_cnt};
         total++;
         if (act_a !== exp_a) begin
            bad++;
            $display("FAIL random_a cycle %0d: got %h, want %h", n, act_a, exp_a);
         end
         total++;
         if (act_b !== exp_b) begin
            bad++;
            $display("FAIL random_b cycle %0d: got %h, want %h", n, act_b, exp_b);
         end
         tick();
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_simultaneous();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
